// File: rtl/fp32_neuron_accumulator.sv
// Purpose: folds NUM_TERMS fp32 products into a bias-seeded running sum for one neuron.
// Latency: one product per cycle; out_valid rises the cycle after the last accepted product.
// Backpressure: in_ready only in ACCUM; result held stable in DONE until out_ready (FP32_ACC_RELU_EN adds ReLU).
module fp32_neuron_accumulator #(
  parameter int NUM_TERMS = 784,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic [CNT_W-1:0] term_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_TERMS - 1);

  state_t      state_q, state_d;
  logic [31:0] acc;
  logic [31:0] acc_sum;
  logic [31:0] acc_step;
  logic [31:0] act;

  // Combinational fp32 add of two normal operands (the implicit 1 is always
  // inserted), round-to-nearest-even, flush-to-zero on underflow.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [7:0]  d;
    logic [26:0] ma, mb, mb_sh, m;
    logic [53:0] mb_full;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic        found;
    logic [9:0]  e;
    logic        rnd;
    logic [24:0] mr;
    logic [31:0] r;
    // larger magnitude operand goes in a; its sign is the result sign
    if (x[30:0] >= y[30:0]) begin
      a = x;
      b = y;
    end else begin
      a = y;
      b = x;
    end
    d       = a[30:23] - b[30:23];
    ma      = {1'b1, a[22:0], 3'b000};
    mb      = {1'b1, b[22:0], 3'b000};
    mb_full = {mb, 27'd0} >> d;
    // bits shifted out collapse into the sticky bit
    if (d > 8'd26) mb_sh = 27'd1;
    else           mb_sh = mb_full[53:27] | {26'd0, |mb_full[26:0]};
    e     = {2'b00, a[30:23]};
    m     = 27'd0;
    lz    = 5'd0;
    found = 1'b0;
    if (a[31] == b[31]) begin
      sum = {1'b0, ma} + {1'b0, mb_sh};
      if (sum[27]) begin
        m = sum[27:1] | {26'd0, sum[0]};
        e = e + 10'd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      sum = {1'b0, ma} - {1'b0, mb_sh};
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (sum[i]) found = 1'b1;
          else        lz = lz + 5'd1;
        end
      end
      // exact cancellation or underflow both produce a zero result
      if (!found || e <= {5'd0, lz}) begin
        m = 27'd0;
        e = 10'd0;
      end else begin
        m = sum[26:0] << lz;
        e = e - {5'd0, lz};
      end
    end
    rnd = m[2] & (m[1] | m[0] | m[3]);
    mr  = {1'b0, m[26:3]} + {24'd0, rnd};
    if (mr[24]) begin
      e  = e + 10'd1;
      mr = mr >> 1;
    end
    if (e == 10'd0)        r = {a[31], 31'd0};
    else if (e >= 10'd255) r = {a[31], 8'hFF, 23'd0};
    else                   r = {a[31], e[7:0], mr[22:0]};
    return r;
  endfunction

  // Zero/denormal wrapper around the adder: zero products leave acc alone,
  // a zero acc takes the product directly, and any zero sum is stored as +0.
  always_comb begin
    acc_sum  = fp_add(acc, in_data);
    acc_step = acc;
    if (in_data[30:23] == 8'd0)  acc_step = acc;
    else if (acc[30:23] == 8'd0) acc_step = in_data;
    else if (acc_sum[30:0] == 31'd0) acc_step = 32'h0;
    else acc_step = acc_sum;
  end

`ifdef FP32_ACC_RELU_EN
  assign act = acc[31] ? 32'h0 : acc;
`else
  assign act = acc;
`endif

  // Next-state logic: start is only honoured in IDLE, the last handshake ends ACCUM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (NUM_TERMS == 0) ? DONE : ACCUM;
      ACCUM:   if (in_valid && term_count == LAST_TERM) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, running sum and term counter; a denormal/zero bias loads as +0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc        <= 32'h0;
      term_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        acc        <= (bias[30:23] == 8'd0) ? 32'h0 : bias;
        term_count <= '0;
      end else if (state_q == ACCUM && in_valid) begin
        acc        <= acc_step;
        term_count <= term_count + 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = (state_q == DONE) ? act : 32'h0;

endmodule

// File: tb/tb_fp32_neuron_accumulator.sv
// Purpose: directed self-checking bench for fp32_neuron_accumulator with NUM_TERMS=4.
// Latency: checks sample outputs 1 ns after each rising edge.
// Backpressure: exercises upstream gaps and downstream out_ready stalls.
module tb_fp32_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [31:0] bias, in_data;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;
  logic [9:0]  term_count;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] F_1P0  = 32'h3F800000;
  localparam logic [31:0] F_M1P0 = 32'hBF800000;

  fp32_neuron_accumulator #(.NUM_TERMS(4), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .term_count(term_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bias = 32'h0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (term_count !== 10'd0) begin errors++; $display("FAIL reset_term_count got %0d want 0", term_count); end
  endtask

  task automatic test_basic;
    logic [31:0] prod [4];
    prod[0] = 32'h3F800000; prod[1] = 32'h40000000; prod[2] = 32'h3F000000; prod[3] = 32'h00000000;
    out_ready = 1'b1;
    start = 1'b1; bias = F_1P0;
    tick();
    start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    checks++; if (term_count !== 10'd0) begin errors++; $display("FAIL basic_count0 got %0d want 0", term_count); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = prod[i];
      tick();
      checks++; if (out_valid !== (i == 3)) begin errors++; $display("FAIL basic_out_valid_%0d got %b want %b", i, out_valid, (i == 3)); end
    end
    in_valid = 1'b0;
    checks++; if (out_data !== 32'h40900000) begin errors++; $display("FAIL basic_sum got %h want 40900000", out_data); end
    checks++; if (term_count !== 10'd4) begin errors++; $display("FAIL basic_count got %0d want 4", term_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_done_in_ready got %b want 0", in_ready); end
    tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_return_idle got busy=%b ov=%b want 0 0", busy, out_valid); end
  endtask

  task automatic test_negative;
    logic [31:0] exp_v;
`ifdef FP32_ACC_RELU_EN
    exp_v = 32'h00000000;
`else
    exp_v = 32'hC0800000;
`endif
    start = 1'b1; bias = 32'h0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = F_M1P0;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL neg_out_valid got %b want 1", out_valid); end
    checks++; if (out_data !== exp_v) begin errors++; $display("FAIL neg_sum got %h want %h", out_data, exp_v); end
    tick();
  endtask

  task automatic test_gaps;
    logic [6:0] pat;
    pat = 7'b1011001;
    start = 1'b1; bias = F_1P0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = pat[6-k]; in_data = F_1P0;
      tick();
      checks++; if (out_valid !== (k == 6)) begin errors++; $display("FAIL gaps_out_valid_%0d got %b want %b", k, out_valid, (k == 6)); end
    end
    in_valid = 1'b0;
    checks++; if (term_count !== 10'd4) begin errors++; $display("FAIL gaps_count got %0d want 4", term_count); end
    checks++; if (out_data !== 32'h40A00000) begin errors++; $display("FAIL gaps_sum got %h want 40A00000", out_data); end
    tick();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    start = 1'b1; bias = F_1P0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = F_1P0;
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      start = (c == 2); bias = 32'h40400000;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h40A00000)
        begin errors++; $display("FAIL bp_hold_%0d got ov=%b ir=%b data=%h want 1 0 40A00000", c, out_valid, in_ready, out_data); end
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    checks++; if (out_data !== 32'h40A00000 || term_count !== 10'd4) begin errors++; $display("FAIL bp_after_start got %h/%0d want 40A00000/4", out_data, term_count); end
    out_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got busy=%b ov=%b want 0 0", busy, out_valid); end
  endtask

  task automatic test_cancel;
    logic [31:0] prod [4];
    prod[0] = 32'hC0400000; prod[1] = 32'h40000000; prod[2] = 32'h0; prod[3] = 32'h0;
    start = 1'b1; bias = 32'h40400000;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = prod[i];
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_data !== 32'h40000000) begin errors++; $display("FAIL cancel_sum got %h want 40000000", out_data); end
    tick();
  endtask

  task automatic test_reset_mid;
    start = 1'b1; bias = F_1P0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = F_1P0;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (term_count !== 10'd2) begin errors++; $display("FAIL mid_count2 got %0d want 2", term_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || term_count !== 10'd0)
      begin errors++; $display("FAIL mid_reset got busy=%b ir=%b cnt=%0d want 0 0 0", busy, in_ready, term_count); end
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_beats_start got busy=%b want 0", busy); end
    start = 1'b1; bias = 32'h0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = F_1P0;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h40800000) begin errors++; $display("FAIL mid_resum got ov=%b data=%h want 1 40800000", out_valid, out_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_gaps();
    test_backpressure();
    test_cancel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
